// File: rtl/counter_step_ctrl.sv
// Button-to-step controller: synchronize, debounce and arbitrate UP/DOWN buttons into one-cycle steps.
// Define COUNTER_STEP_AUTO_REPEAT_EN to enable hold-to-repeat; otherwise one step per press.
module counter_step_ctrl #(
   parameter int TICK_DIV           = 125000,
   parameter int DEBOUNCE_TICKS     = 20,
   parameter int REPEAT_DELAY_TICKS = 500,
   parameter int REPEAT_RATE_TICKS  = 100
) (
   input  logic CLOCK,
   input  logic RESET,
   input  logic BTN_UP,
   input  logic BTN_DOWN,
   output logic STEP_UP,
   output logic STEP_DOWN,
   output logic BUSY,
   output logic TICK
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_TICKS - 1);

   typedef enum logic [1:0] {IDLE, DELAY, REPEAT, WAIT_REL} state_t;

   // Index 0 is UP, index 1 is DOWN throughout.
   logic [1:0]          sync1_q, sync2_q, deb_q;
   logic [1:0][DW-1:0]  dcnt_q;
   logic [PW-1:0]       presc_q;
   logic                tick;
   state_t              state_q, state_d;
   logic                owner_q, owner_d;
   logic                step_up_q, step_up_d, step_dn_q, step_dn_d;
   logic                own_held;

   assign tick      = (presc_q == PRESC_LAST);
   assign TICK      = tick;
   assign BUSY      = (state_q != IDLE);
   assign STEP_UP   = step_up_q;
   assign STEP_DOWN = step_dn_q;
   assign own_held  = owner_q ? deb_q[1] : deb_q[0];

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         sync1_q <= '0;
         sync2_q <= '0;
         presc_q <= '0;
      end else begin
         sync1_q <= {BTN_DOWN, BTN_UP};
         sync2_q <= sync1_q;
         presc_q <= tick ? '0 : presc_q + 1'b1;
      end
   end

   // A level is accepted only after DEBOUNCE_TICKS consecutive disagreeing ticks.
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         deb_q  <= '0;
         dcnt_q <= '0;
      end else if (tick) begin
         for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
               dcnt_q[i] <= '0;
            end else if (dcnt_q[i] == DEB_LAST) begin
               deb_q[i]  <= ~deb_q[i];
               dcnt_q[i] <= '0;
            end else begin
               dcnt_q[i] <= dcnt_q[i] + 1'b1;
            end
         end
      end
   end

`ifdef COUNTER_STEP_AUTO_REPEAT_EN
   localparam int RMAX = (REPEAT_DELAY_TICKS > REPEAT_RATE_TICKS) ? REPEAT_DELAY_TICKS
                                                                  : REPEAT_RATE_TICKS;
   localparam int RW = $clog2(RMAX + 1);
   localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY_TICKS - 1);
   localparam logic [RW-1:0] RR_LAST = RW'(REPEAT_RATE_TICKS - 1);

   logic [RW-1:0] rcnt_q, rcnt_d;

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) rcnt_q <= '0;
      else       rcnt_q <= rcnt_d;
   end
`else
   logic unused_cfg;
   assign unused_cfg = (REPEAT_DELAY_TICKS > 0) ^ (REPEAT_RATE_TICKS > 0);
`endif

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      step_up_d = 1'b0;
      step_dn_d = 1'b0;
`ifdef COUNTER_STEP_AUTO_REPEAT_EN
      rcnt_d    = rcnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (deb_q[0] ^ deb_q[1]) begin
               owner_d   = deb_q[1];
               step_up_d = deb_q[0];
               step_dn_d = deb_q[1];
`ifdef COUNTER_STEP_AUTO_REPEAT_EN
               rcnt_d    = '0;
               state_d   = DELAY;
`else
               state_d   = WAIT_REL;
`endif
            end
         end
`ifdef COUNTER_STEP_AUTO_REPEAT_EN
         // Release is checked first so a release coinciding with a repeat tick never steps.
         DELAY, REPEAT: begin
            if (!own_held) begin
               rcnt_d  = '0;
               state_d = IDLE;
            end else if (tick) begin
               if (rcnt_q == ((state_q == DELAY) ? RD_LAST : RR_LAST)) begin
                  step_up_d = ~owner_q;
                  step_dn_d = owner_q;
                  rcnt_d    = '0;
                  state_d   = REPEAT;
               end else begin
                  rcnt_d = rcnt_q + 1'b1;
               end
            end
         end
`endif
         WAIT_REL: begin
            if (!own_held) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         state_q   <= IDLE;
         owner_q   <= 1'b0;
         step_up_q <= 1'b0;
         step_dn_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         step_up_q <= step_up_d;
         step_dn_q <= step_dn_d;
      end
   end

endmodule

// File: tb/tb_counter_step_ctrl.sv
// Directed bench for counter_step_ctrl with TICK_DIV=4, DEBOUNCE_TICKS=3, REPEAT_DELAY=8, REPEAT_RATE=2.
module tb_counter_step_ctrl;

   localparam int TD = 4, DB = 3, RD = 8, RR = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic bu = 1'b0, bd = 1'b0;
   logic step_up, step_dn, busy, tick;

   int cyc = 0;
   int n_tests = 0, n_fail = 0;
   int up_q[$], dn_q[$], fall_q[$];
   int both_cnt = 0, busy_cnt = 0;
   logic busy_prev = 1'b0;

   always #5 clk = ~clk;

   counter_step_ctrl #(
      .TICK_DIV(TD), .DEBOUNCE_TICKS(DB),
      .REPEAT_DELAY_TICKS(RD), .REPEAT_RATE_TICKS(RR)
   ) dut (
      .CLOCK(clk), .RESET(rst), .BTN_UP(bu), .BTN_DOWN(bd),
      .STEP_UP(step_up), .STEP_DOWN(step_dn), .BUSY(busy), .TICK(tick)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Event log sampled on the falling edge; tests look at entries added since they started.
   always @(negedge clk) begin
      if (step_up) up_q.push_back(cyc);
      if (step_dn) dn_q.push_back(cyc);
      if (busy_prev && !busy) fall_q.push_back(cyc);
      if (step_up && step_dn) both_cnt <= both_cnt + 1;
      if (busy) busy_cnt <= busy_cnt + 1;
      busy_prev <= busy;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      int k, b_up, b_dn, b_f, b_busy, bad, r, lat, fi;

      #1;
      check("rst_step_up", step_up, 0);
      check("rst_step_dn", step_dn, 0);
      check("rst_busy", busy, 0);
      check("rst_tick", tick, 0);
      cycles(3);
      rst = 1'b0;
      cycles(5);

      // Single long press of UP
      b_up = up_q.size(); b_dn = dn_q.size(); b_f = fall_q.size();
      bu = 1'b1; k = cyc;
`ifdef COUNTER_STEP_AUTO_REPEAT_EN
      cycles(100);
`else
      cycles(200);
      check("t1_busy_held", busy, 1);
`endif
      bu = 1'b0;
      cycles(40);
      check("t1_no_down", dn_q.size() - b_dn, 0);
      check("t1_busy_end", busy, 0);
      check("t1_one_idle_entry", fall_q.size() - b_f, 1);
      if (up_q.size() > b_up) begin
         lat = up_q[b_up] - k;
         check("t1_first_lat_in_11_15", (lat >= 11 && lat <= 15), 1);
         if (fall_q.size() > b_f)
            check("t1_steps_before_idle", up_q[up_q.size()-1] < fall_q[b_f], 1);
      end else begin
         check("t1_first_step_seen", 0, 1);
      end
`ifdef COUNTER_STEP_AUTO_REPEAT_EN
      check("t1_n_up_ge8", (up_q.size() - b_up) >= 8, 1);
      if (up_q.size() - b_up >= 3) begin
         lat = up_q[b_up+1] - up_q[b_up];
         check("t1_first_repeat_31_32", (lat >= RD*TD-1 && lat <= RD*TD), 1);
         bad = 0;
         for (int i = b_up + 2; i < up_q.size(); i++)
            if (up_q[i] - up_q[i-1] != RR*TD) bad++;
         check("t1_rate_gaps", bad, 0);
      end
`else
      check("t1_exactly_one_up", up_q.size() - b_up, 1);
`endif

      // Bounce on DOWN: toggle every 3 cycles for 30 cycles, then hold
      b_up = up_q.size(); b_dn = dn_q.size();
      for (int i = 0; i < 10; i++) begin
         bd = (i % 2 == 0);
         cycles(3);
      end
      check("t2_no_step_bounce", (dn_q.size() - b_dn) + (up_q.size() - b_up), 0);
      bd = 1'b1;
      cycles(20);
      check("t2_one_down", dn_q.size() - b_dn, 1);
      bd = 1'b0;
      cycles(30);
      check("t2_still_one_down", dn_q.size() - b_dn, 1);
      check("t2_no_up", up_q.size() - b_up, 0);
      check("t2_busy_end", busy, 0);

      // Simultaneous press: no owner is granted
      b_up = up_q.size(); b_dn = dn_q.size(); b_busy = busy_cnt;
      bu = 1'b1; bd = 1'b1;
      cycles(200);
      check("t3_no_up", up_q.size() - b_up, 0);
      check("t3_no_down", dn_q.size() - b_dn, 0);
      check("t3_busy_never", busy_cnt - b_busy, 0);
      bu = 1'b0; bd = 1'b0;
      cycles(30);

      // Lock: UP owns, DOWN pressed later, DOWN granted after UP's release
      b_up = up_q.size(); b_dn = dn_q.size(); b_f = fall_q.size();
      bu = 1'b1;
      cycles(20);
      bd = 1'b1;
      cycles(40);
      bu = 1'b0;
      cycles(60);
      bd = 1'b0;
      cycles(40);
      check("t4_up_seen", up_q.size() > b_up, 1);
      if (fall_q.size() > b_f && dn_q.size() > b_dn) begin
         fi = fall_q[b_f];
         check("t4_down_one_after_idle", dn_q[b_dn], fi + 1);
         bad = 0;
         for (int i = b_up; i < up_q.size(); i++)
            if (up_q[i] >= fi) bad++;
         check("t4_up_only_while_owner", bad, 0);
      end else begin
         check("t4_handover_events", 0, 1);
      end
      check("t4_busy_end", busy, 0);

      // Reset while UP is held (in REPEAT when auto-repeat is built in)
      bu = 1'b1;
      cycles(60);
      rst = 1'b1;
      #1;
      check("t5_rst_step_up", step_up, 0);
      check("t5_rst_step_dn", step_dn, 0);
      check("t5_rst_busy", busy, 0);
      check("t5_rst_tick", tick, 0);
      cycles(2);
      rst = 1'b0; r = cyc; b_up = up_q.size();
      cycles(40);
      if (up_q.size() > b_up)
         check("t5_fresh_step_ge11", (up_q[b_up] - r) >= 11, 1);
      else
         check("t5_fresh_step_seen", 0, 1);
      bu = 1'b0;
      cycles(30);
      check("t5_busy_end", busy, 0);

      check("mutex_steps", both_cnt, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
